// File: rtl/fetch_pkg.sv
// Shared fetch/decode types and instruction field slicers.
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [6:0] inst_opcode_f(input logic [XLEN-1:0] inst);
    return inst[6:0];
  endfunction

  function automatic logic [2:0] inst_funct3_f(input logic [XLEN-1:0] inst);
    return inst[14:12];
  endfunction

  function automatic logic [6:0] inst_funct7_f(input logic [XLEN-1:0] inst);
    return inst[31:25];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Type-generic synchronous FIFO with a flush that overrides push/pop.
module sync_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output T                 head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~flush & (~full | pop);
  assign do_pop  = pop & ~flush & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC ownership, credited imem requests, response FIFO, redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  localparam int unsigned CNT_W      = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W      = CNT_W + 1;
  localparam logic [31:0] PC_STEP    = 32'(INST_BYTES);
  localparam logic [31:0] ALIGN_MASK = ~(PC_STEP - 32'd1);

  logic [31:0]      pc;
  logic [31:0]      pc_next;
  logic [31:0]      rsp_pc;
  logic [31:0]      rsp_pc_next;
  logic [31:0]      redirect_base;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] discard_next;
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] credit_used;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             issue;
  logic             rsp_fire;
  logic             push;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  // Request side: a credit is held from issue until the entry leaves the FIFO.
  assign pop            = inst_valid & inst_ready;
  assign credit_used    = SUM_W'(outstanding) + SUM_W'(fifo_count) - SUM_W'(pop);
  assign imem_req_valid = ~redirect_valid & (credit_used < SUM_W'(DEPTH));
  assign imem_req_addr  = pc;
  assign issue          = imem_req_valid & imem_req_ready;
  assign redirect_base  = redirect_pc & ALIGN_MASK;

  // Response side; a response with nothing outstanding is ignored.
  assign rsp_fire   = imem_rsp_valid & (outstanding != '0);
  assign push       = rsp_fire & (discard == '0) & ~redirect_valid & (~fifo_full | pop);
  assign push_entry = '{pc: rsp_pc, inst: imem_rsp_data};

  always_comb begin
    pc_next          = pc;
    rsp_pc_next      = rsp_pc;
    outstanding_next = outstanding + CNT_W'(issue) - CNT_W'(rsp_fire);
    discard_next     = discard;
    if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old stream.
      pc_next      = redirect_base;
      rsp_pc_next  = redirect_base;
      discard_next = outstanding - CNT_W'(rsp_fire);
    end else begin
      if (issue)                       pc_next      = pc + PC_STEP;
      if (push)                        rsp_pc_next  = rsp_pc + PC_STEP;
      if (rsp_fire && discard != '0)   discard_next = discard - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC & ALIGN_MASK;
      rsp_pc      <= RESET_PC & ALIGN_MASK;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      pc          <= pc_next;
      rsp_pc      <= rsp_pc_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
    end
  end

  sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

  assign inst_valid = ~fifo_empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign opcode     = inst_opcode_f(head.inst);
  assign funct3     = inst_funct3_f(head.inst);
  assign funct7     = inst_funct7_f(head.inst);

  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding != '0));

endmodule
